vc_phase_timer: RTL



---
 rtl/vc_pkg.sv | 20 ++
 rtl/vc_lfsr16.sv | 21 ++
 rtl/vc_phase_timer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vc_pkg.sv
// Shared constants for the voice-corruptor phase handshake.
// Phase encodings match the sequencer. The LFSR constants are only used
// when VC_RAND_LEN_EN is defined.
package vc_pkg;

    // Phase encodings; also the bit index of each phase's enable/pulse
    localparam logic [1:0] PH_A  = 2'b00;
    localparam logic [1:0] PH_AB = 2'b01;
    localparam logic [1:0] PH_B  = 2'b10;
    localparam logic [1:0] PH_BA = 2'b11;

    // Mixer weight of path B at the two ends of a crossfade
    localparam logic [7:0] COEF_ALL_A = 8'd0;
    localparam logic [7:0] COEF_ALL_B = 8'd255;

    // Maximal 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/vc_lfsr16.sv
// 16-bit maximal-length LFSR used to jitter phase hold lengths.
// Instantiated only when VC_RAND_LEN_EN is defined.
module vc_lfsr16
    import vc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    output logic [15:0] q
);

    // Shift left, feeding back the XOR of the tap bits; reseed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/vc_phase_timer.sv
// Counter/timer end of the voice-corruptor phase handshake.
// Counts sample ticks per phase, returns one-clk terminal pulses and the
// crossfade coefficient for the mixer.
// Optional feature: define VC_RAND_LEN_EN to add LFSR jitter to A/B lengths.
module vc_phase_timer
    import vc_pkg::*;
#(
    parameter int unsigned CW      = 16,
    parameter int unsigned XF_LOG2 = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          A_en,
    input  logic          AB_en,
    input  logic          B_en,
    input  logic          BA_en,
    input  logic [CW-1:0] len_a,
    input  logic [CW-1:0] len_b,
    output logic          countA,
    output logic          countAB,
    output logic          countB,
    output logic          countBA,
    output logic [7:0]    fade_coef,
    output logic          phase_err
);

    // Crossfade length; saturates if 2^XF_LOG2 does not fit in CW bits
    localparam logic [CW-1:0] XF_LEN   = (XF_LOG2 >= CW) ? {CW{1'b1}} : (CW'(1) << XF_LOG2);
    localparam int unsigned   XF_SHIFT = XF_LOG2 - 8;

    logic [3:0]    en;
    logic [3:0]    prev_en_q;
    logic [1:0]    ph;
    logic          active;
    logic          multi;
    logic          entry;
    logic [CW-1:0] counter_q;
    logic [CW-1:0] len_q;
    logic          done_q;
    logic [3:0]    pulse_q;
    logic          phase_err_q;
    logic [7:0]    fade_q;
    logic [CW-1:0] hold_len;
    logic [CW-1:0] hold_base;
    logic [CW:0]   hold_sum;
    logic [CW-1:0] entry_len;
    logic [CW-1:0] coef_cnt;
    logic [CW-1:0] coef_shift;
    logic [7:0]    ramp;
    logic [7:0]    coef_next;
    logic [7:0]    jitter;

    assign en = {BA_en, B_en, AB_en, A_en};

`ifdef VC_RAND_LEN_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr_hi;

    vc_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (tick),
        .q     (lfsr_q)
    );

    assign jitter         = lfsr_q[7:0];
    assign unused_lfsr_hi = ^lfsr_q[15:8];
`else
    assign jitter = 8'd0;
`endif

    // Priority select A > AB > B > BA, overlap detect and fresh-entry detect
    always_comb begin
        active = |en;
        multi  = (en & (en - 4'd1)) != 4'd0;
        if (A_en) begin
            ph = PH_A;
        end else if (AB_en) begin
            ph = PH_AB;
        end else if (B_en) begin
            ph = PH_B;
        end else begin
            ph = PH_BA;
        end
        entry = active && !prev_en_q[ph];
    end

    // Length to latch on entry: hold phases clamp 0 to 1 and add jitter with saturation
    always_comb begin
        hold_len  = (ph == PH_A) ? len_a : len_b;
        hold_base = (hold_len == '0) ? CW'(1) : hold_len;
        hold_sum  = {1'b0, hold_base} + {{(CW - 7){1'b0}}, jitter};
        if (ph == PH_AB || ph == PH_BA) begin
            entry_len = XF_LEN;
        end else if (hold_sum[CW]) begin
            entry_len = '1;
        end else begin
            entry_len = hold_sum[CW-1:0];
        end
    end

    // Coefficient from the counter; an entering phase starts its ramp from zero
    always_comb begin
        coef_cnt   = entry ? '0 : counter_q;
        coef_shift = coef_cnt >> XF_SHIFT;
        ramp       = (coef_shift > CW'(255)) ? 8'd255 : coef_shift[7:0];
        case (ph)
            PH_A:    coef_next = COEF_ALL_A;
            PH_AB:   coef_next = ramp;
            PH_B:    coef_next = COEF_ALL_B;
            default: coef_next = COEF_ALL_B - ramp;
        endcase
    end

    // Counter, length latch, terminal pulses, error flag and coefficient register
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_en_q   <= 4'b0000;
            counter_q   <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            pulse_q     <= 4'b0000;
            phase_err_q <= 1'b0;
            fade_q      <= COEF_ALL_A;
        end else begin
            prev_en_q   <= en;
            phase_err_q <= multi;
            pulse_q     <= 4'b0000;
            if (!active) begin
                counter_q <= '0;
                done_q    <= 1'b0;
            end else if (entry) begin
                // Entry wins over a coincident tick
                counter_q <= '0;
                done_q    <= 1'b0;
                len_q     <= entry_len;
            end else if (tick && !done_q) begin
                if (counter_q == len_q - CW'(1)) begin
                    counter_q <= len_q;
                    done_q    <= 1'b1;
                    pulse_q   <= 4'(1) << ph;
                end else begin
                    counter_q <= counter_q + CW'(1);
                end
            end
            if (active) begin
                fade_q <= coef_next;
            end
        end
    end

    assign countA    = pulse_q[PH_A];
    assign countAB   = pulse_q[PH_AB];
    assign countB    = pulse_q[PH_B];
    assign countBA   = pulse_q[PH_BA];
    assign fade_coef = fade_q;
    assign phase_err = phase_err_q;

endmodule
